// File: rtl/sram_responder.sv
// Cycle-based responder for the external 32-bit SRAM bus: byte-lane writes and latency-delayed reads on DQ.
// Optional protocol checking is built only when SRAM_RESPONDER_CHECK_EN is defined.
module sram_responder #(
    parameter int    ADDR_WIDTH   = 17,
    parameter int    READ_LATENCY = 2,
    parameter string INIT_FILE    = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] SRAM_ADDR,
    inout  wire  [31:0]           SRAM_DQ,
    input  logic                  SRAM_WE_N,
    input  logic                  SRAM_CE_N,
    input  logic                  SRAM_OE_N,
    input  logic                  SRAM_UB_N,
    input  logic                  SRAM_LB_N,
    output logic [15:0]           read_count,
    output logic [15:0]           write_count,
    output logic                  access_err
);

    localparam logic [3:0] LAT_RELOAD = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_HOLD} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            lat_q;
    logic                  drive_q;
    logic [15:0]           rd_cnt_q;
    logic [15:0]           wr_cnt_q;
    logic [31:0]           mem [0:(1<<ADDR_WIDTH)-1];

    logic        sel, wr, rd, addr_chg, commit;
    logic        out_ok, hi_en, lo_en;
    logic [31:0] rdata;

    assign sel      = !SRAM_CE_N;
    assign wr       = sel & !SRAM_WE_N;
    assign rd       = sel & SRAM_WE_N & !SRAM_OE_N;
    assign addr_chg = (SRAM_ADDR != addr_q);

    // A write commits on a fresh request or when the address moves under a held write.
    always_comb begin
        commit = 1'b0;
        if (!rst && wr) begin
            case (state_q)
                IDLE, RD_DRIVE: commit = 1'b1;
                WR_HOLD:        commit = addr_chg;
                default:        commit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            if (!SRAM_LB_N) mem[SRAM_ADDR][15:0]  <= SRAM_DQ[15:0];
            if (!SRAM_UB_N) mem[SRAM_ADDR][31:16] <= SRAM_DQ[31:16];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            drive_q  <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (commit) wr_cnt_q <= wr_cnt_q + 16'd1;
            case (state_q)
                IDLE: begin
                    if (wr) begin
                        addr_q  <= SRAM_ADDR;
                        state_q <= WR_HOLD;
                    end else if (rd) begin
                        addr_q  <= SRAM_ADDR;
                        lat_q   <= LAT_RELOAD;
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (!rd) begin
                        state_q <= IDLE;
                    end else if (addr_chg) begin
                        addr_q <= SRAM_ADDR;
                        lat_q  <= LAT_RELOAD;
                    end else if (lat_q == 4'd0) begin
                        drive_q  <= 1'b1;
                        rd_cnt_q <= rd_cnt_q + 16'd1;
                        state_q  <= RD_DRIVE;
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                RD_DRIVE: begin
                    if (wr) begin
                        drive_q <= 1'b0;
                        addr_q  <= SRAM_ADDR;
                        state_q <= WR_HOLD;
                    end else if (!rd) begin
                        drive_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (addr_chg) begin
                        drive_q <= 1'b0;
                        addr_q  <= SRAM_ADDR;
                        lat_q   <= LAT_RELOAD;
                        state_q <= RD_WAIT;
                    end
                end
                WR_HOLD: begin
                    if (!wr) state_q <= IDLE;
                    else if (addr_chg) addr_q <= SRAM_ADDR;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output gating also follows the live strobes so DQ never fights a writer or a deselected bus.
    assign rdata  = mem[addr_q];
    assign out_ok = drive_q & sel & SRAM_WE_N & !SRAM_OE_N;
    assign hi_en  = out_ok & !SRAM_UB_N;
    assign lo_en  = out_ok & !SRAM_LB_N;

    assign SRAM_DQ[31:16] = hi_en ? rdata[31:16] : 16'bz;
    assign SRAM_DQ[15:0]  = lo_en ? rdata[15:0]  : 16'bz;

    assign read_count  = rd_cnt_q;
    assign write_count = wr_cnt_q;

`ifdef SRAM_RESPONDER_CHECK_EN
    logic err_q;
    logic ev_both, ev_hold, ev_lane;

    assign ev_both = sel & !SRAM_WE_N & !SRAM_OE_N;
    assign ev_hold = (state_q == WR_HOLD) & addr_chg;
    assign ev_lane = rd & SRAM_UB_N & SRAM_LB_N;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            if (ev_both) $display("[%0t] sram_responder: WE_N and OE_N both asserted", $time);
            if (ev_hold) $display("[%0t] sram_responder: address changed during write hold", $time);
            if (ev_lane) $display("[%0t] sram_responder: read with both lanes disabled", $time);
            if (ev_both | ev_hold | ev_lane) err_q <= 1'b1;
        end
    end

    assign access_err = err_q;
`else
    assign access_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: stimulus queues expected read responses, a monitor checks them on completion.
module tb_sram_responder;

    localparam int AW  = 17;
    localparam int LAT = 2;
`ifdef SRAM_RESPONDER_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] sram_addr = '0;
    logic          we_n = 1'b1, ce_n = 1'b1, oe_n = 1'b1, ub_n = 1'b0, lb_n = 1'b0;
    logic [31:0]   dq_drv = '0;
    logic          dq_oe = 1'b0;
    wire  [31:0]   sram_dq;
    logic [15:0]   read_count, write_count;
    logic          access_err;

    assign sram_dq = dq_oe ? dq_drv : 32'bz;

    sram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT), .INIT_FILE("")) dut (
        .clk        (clk),
        .rst        (rst),
        .SRAM_ADDR  (sram_addr),
        .SRAM_DQ    (sram_dq),
        .SRAM_WE_N  (we_n),
        .SRAM_CE_N  (ce_n),
        .SRAM_OE_N  (oe_n),
        .SRAM_UB_N  (ub_n),
        .SRAM_LB_N  (lb_n),
        .read_count (read_count),
        .write_count(write_count),
        .access_err (access_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // A lane counts as released when it floats (4-state) or resolves to zero (2-state).
    function automatic logic released(input logic [31:0] v, input logic [31:0] m);
        logic [31:0] x;
        x = v & ~m;
        return $isunknown(x) || (x == 32'h0);
    endfunction

    logic [15:0] prev_rc = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_rc = read_count;
        end else if (read_count != prev_rc) begin
            prev_rc = read_count;
            if (exp_q.size() == 0) begin
                chk("unexpected_read", {16'h0, read_count}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rd_data", sram_dq & e.mask, e.data & e.mask);
                chk("rd_lanes_released", 32'(released(sram_dq, e.mask)), 32'd1);
                chk("rd_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0; dq_oe = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic ub, input logic lb);
        sram_addr = a; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; ub_n = ub; lb_n = lb;
        dq_drv = d; dq_oe = 1'b1;
        tick();
        bus_idle();
        tick();
    endtask

    task automatic start_read(input logic [AW-1:0] a, input logic ub, input logic lb,
                              input logic [31:0] d, input logic [31:0] m);
        sram_addr = a; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = ub; lb_n = lb; dq_oe = 1'b0;
        exp_q.push_back(exp_t'{data: d, mask: m, cyc: cyc + 1 + LAT});
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic ub, input logic lb,
                           input logic [31:0] d, input logic [31:0] m);
        start_read(a, ub, lb, d, m);
        repeat (LAT + 2) tick();
        bus_idle();
        tick();
    endtask

    initial begin
        bus_idle();
        repeat (3) tick();
        chk("reset_read_count", {16'h0, read_count}, 32'h0);
        chk("reset_write_count", {16'h0, write_count}, 32'h0);
        chk("reset_access_err", {31'h0, access_err}, 32'h0);
        chk("reset_dq_released", 32'(released(sram_dq, 32'h0)), 32'd1);
        rst = 1'b0;
        tick();

        // Basic write then full-word read
        do_write(17'h00010, 32'hDEADBEEF, 1'b0, 1'b0);
        do_read(17'h00010, 1'b0, 1'b0, 32'hDEADBEEF, 32'hFFFF_FFFF);
        chk("t1_write_count", {16'h0, write_count}, 32'd1);
        chk("t1_read_count", {16'h0, read_count}, 32'd1);

        // Lower-lane-only overwrite
        do_write(17'h00020, 32'h11223344, 1'b0, 1'b0);
        do_write(17'h00020, 32'hAAAA5555, 1'b1, 1'b0);
        do_read(17'h00020, 1'b0, 1'b0, 32'h11225555, 32'hFFFF_FFFF);
        chk("t2_write_count", {16'h0, write_count}, 32'd3);

        // Aborted read: OE_N rises one cycle after the request
        do_write(17'h00030, 32'h30303030, 1'b0, 1'b0);
        sram_addr = 17'h00030; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
        tick();
        oe_n = 1'b1;
        tick();
        chk("t3_abort_dq_released", 32'(released(sram_dq, 32'h0)), 32'd1);
        oe_n = 1'b0;
        tick();
        chk("t3_abort_dq_still_released", 32'(released(sram_dq, 32'h0)), 32'd1);
        bus_idle();
        tick();
        chk("t3_read_count_unchanged", {16'h0, read_count}, 32'd2);

        // Read with the upper lane disabled
        do_read(17'h00010, 1'b1, 1'b0, 32'h0000BEEF, 32'h0000FFFF);

        // Address change while driving restarts the latency
        start_read(17'h00010, 1'b0, 1'b0, 32'hDEADBEEF, 32'hFFFF_FFFF);
        repeat (LAT + 2) tick();
        sram_addr = 17'h00020;
        exp_q.push_back(exp_t'{data: 32'h11225555, mask: 32'hFFFF_FFFF, cyc: cyc + 1 + LAT});
        tick();
        chk("t5_release_on_addr_change", 32'(released(sram_dq, 32'h0)), 32'd1);
        repeat (LAT + 1) tick();
        bus_idle();
        tick();
        chk("t5_read_count", {16'h0, read_count}, 32'd5);
        chk("t5_access_err_clear", {31'h0, access_err}, 32'h0);

        // WE_N and OE_N together: write wins, responder stays off DQ
        sram_addr = 17'h00040; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
        dq_drv = 32'h0000CAFE; dq_oe = 1'b1;
        tick();
        chk("t6_dq_tb_owned", sram_dq, 32'h0000CAFE);
        bus_idle();
        tick();
        chk("t6_access_err", {31'h0, access_err}, {31'h0, EXP_ERR});
        chk("t6_write_count", {16'h0, write_count}, 32'd5);
        do_read(17'h00040, 1'b0, 1'b0, 32'h0000CAFE, 32'hFFFF_FFFF);

        // Counter wrap over 65536 back-to-back writes
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7_reset_write_count", {16'h0, write_count}, 32'h0);
        chk("t7_reset_access_err", {31'h0, access_err}, 32'h0);
        tick();
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0; dq_oe = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            sram_addr = 17'(32'h10000 + i);
            dq_drv = 32'(i);
            tick();
            if (i == 65534) chk("t7_write_count_max", {16'h0, write_count}, 32'h0000FFFF);
        end
        chk("t7_write_count_wrapped", {16'h0, write_count}, 32'h0);
        bus_idle();
        tick();
        do_read(17'h1FFFF, 1'b0, 1'b0, 32'h0000FFFF, 32'hFFFF_FFFF);
        do_read(17'h10123, 1'b0, 1'b0, 32'h00000123, 32'hFFFF_FFFF);

        // Asynchronous reset while driving
        start_read(17'h00010, 1'b0, 1'b0, 32'hDEADBEEF, 32'hFFFF_FFFF);
        repeat (LAT + 2) tick();
        chk("t8_read_count_before_rst", {16'h0, read_count}, 32'd3);
        rst = 1'b1;
        #1;
        chk("t8_rst_dq_released", 32'(released(sram_dq, 32'h0)), 32'd1);
        chk("t8_rst_read_count", {16'h0, read_count}, 32'h0);
        chk("t8_rst_write_count", {16'h0, write_count}, 32'h0);
        tick();
        bus_idle();
        rst = 1'b0;
        repeat (2) tick();

        chk("pending_reads", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
